// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding the UART serializer through a start/busy handshake, with an idle gap between frames.
// Write-to-tx_start 2 clocks from empty/idle; a write while full is dropped and latches the sticky overflow flag.
// Optional macro UART_TX_QUEUE_ECHO_CR_EN: follow every popped 8'h0D with an injected 8'h0A frame.
module uart_tx_queue #(
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int GAP_CLKS = 868
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);
    localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_REQ  = 3'd2,
        S_WAIT = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    state_t            state;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [GAP_W-1:0]  gap_cnt;
    logic              push;
    logic              pop;
    logic              have_byte;
    logic [ADDR_W:0]   count_nxt;

    // Full is judged on the registered value, so a same-cycle pop never rescues a write.
    assign push = wr_en && !full;

`ifdef UART_TX_QUEUE_ECHO_CR_EN
    logic lf_pend;
    assign pop       = (state == S_LOAD) && !lf_pend;
    assign have_byte = !empty || lf_pend;
`else
    assign pop       = (state == S_LOAD);
    assign have_byte = !empty;
`endif

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (!push && pop)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst_n && push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && full)
                overflow <= 1'b1;
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            gap_cnt  <= '0;
`ifdef UART_TX_QUEUE_ECHO_CR_EN
            lf_pend  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (have_byte && !tx_busy)
                        state <= S_LOAD;
                end
                S_LOAD: begin
`ifdef UART_TX_QUEUE_ECHO_CR_EN
                    if (lf_pend) begin
                        tx_data <= 8'h0A;
                        lf_pend <= 1'b0;
                    end else begin
                        tx_data <= mem[rd_ptr];
                        lf_pend <= (mem[rd_ptr] == 8'h0D);
                    end
`else
                    tx_data <= mem[rd_ptr];
`endif
                    tx_start <= 1'b1;
                    state    <= S_REQ;
                end
                S_REQ: begin
                    if (tx_busy) begin
                        tx_start <= 1'b0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!tx_busy) begin
                        gap_cnt <= '0;
                        state   <= (GAP_CLKS == 0) ? S_IDLE : S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST)
                        state <= S_IDLE;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end
                default: begin
                    state    <= S_IDLE;
                    tx_start <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: serializer model, queue-based reference of accepted/expected frames, scenario tasks.
module tb_uart_tx_queue;
    localparam int DEPTH    = 8;
    localparam int ADDR_W   = 3;
    localparam int GAP      = 16;
    localparam int BUSY_LEN = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [7:0]       wr_data = 8'h00;
    logic             hold_busy = 1'b0;
    logic             bfm_busy = 1'b0;
    logic             bfm_en = 1'b0;
    logic             tx_busy;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic             full;
    logic             empty;
    logic [ADDR_W:0]  count;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state: occupancy, sticky overflow, accepted bytes, pending LF echo.
    int         mcount = 0;
    bit         m_ovf = 1'b0;
    bit         echo_pend = 1'b0;
    bit         prev_start = 1'b0;
    int         busy_cnt = 0;
    logic [7:0] b;
    logic [7:0] exp_q[$];
    logic [7:0] sent_q[$];
    logic [7:0] exp_sent[$];

    assign tx_busy = hold_busy | bfm_busy;

    uart_tx_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP_CLKS(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .tx_busy(tx_busy),
        .tx_start(tx_start), .tx_data(tx_data), .full(full), .empty(empty),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Model and serializer, evaluated just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            mcount = 0;
            m_ovf = 1'b0;
            echo_pend = 1'b0;
            exp_q.delete();
            prev_start = 1'b0;
        end else begin
            if (wr_en) begin
                if (mcount < DEPTH) begin
                    mcount++;
                    exp_q.push_back(wr_data);
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (tx_start && !prev_start) begin
                sent_q.push_back(tx_data);
                if (echo_pend) begin
                    exp_sent.push_back(8'h0A);
                    echo_pend = 1'b0;
                end else if (exp_q.size() > 0) begin
                    b = exp_q.pop_front();
                    exp_sent.push_back(b);
                    mcount--;
`ifdef UART_TX_QUEUE_ECHO_CR_EN
                    if (b == 8'h0D) echo_pend = 1'b1;
`endif
                end
            end
            prev_start = tx_start;
        end
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) bfm_busy = 1'b0;
        end else if (bfm_en && tx_start) begin
            bfm_busy = 1'b1;
            busy_cnt = BUSY_LEN;
        end
    end

    task automatic wait_idle(input int limit, output bit ok);
        int quiet = 0;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (mcount == 0 && !echo_pend && !tx_start && !tx_busy) quiet++;
            else quiet = 0;
            if (quiet >= GAP + 6) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; wr_en = 1'b1; wr_data = 8'hAA;
        repeat (3) @(negedge clk);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b exp 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", tx_data); end
        wr_en = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        bit ok;
        int n;
        sent_q.delete();
        bfm_en = 1'b1;
        wr_en = 1'b1; wr_data = 8'h41;
        @(negedge clk);
        wr_en = 1'b0;
        checks++; if (tx_start !== 1'b0 || count !== 4'd1) begin errors++; $display("FAIL single_n1 start %b count %0d exp 0/1", tx_start, count); end
        @(negedge clk);
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_n2 start got %b exp 0", tx_start); end
        @(negedge clk);
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'h41) begin errors++; $display("FAIL single_n3 start %b data %h exp 1/41", tx_start, tx_data); end
        @(negedge clk);
        checks++; if (tx_start !== 1'b0 || tx_busy !== 1'b1) begin errors++; $display("FAIL single_drop start %b busy %b exp 0/1", tx_start, tx_busy); end
        wr_en = 1'b1; wr_data = 8'h42;
        @(negedge clk);
        wr_en = 1'b0;
        for (int i = 0; i < 50 && tx_busy; i++) @(negedge clk);
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL single_busy_end busy stuck %b", tx_busy); end
        n = 0;
        while (!tx_start && n < 5 * GAP) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n != GAP + 3) begin errors++; $display("FAIL single_gap got %0d clocks exp %0d", n, GAP + 3); end
        checks++; if (tx_data !== 8'h42) begin errors++; $display("FAIL single_second got %h exp 42", tx_data); end
        wait_idle(400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_idle timeout"); end
        checks++; if (sent_q.size() != 2) begin errors++; $display("FAIL single_frames got %0d exp 2", sent_q.size()); end
    endtask

    task automatic test_fill_overflow;
        bit ok;
        logic [7:0] got;
        sent_q.delete();
        bfm_en = 1'b0; hold_busy = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            if (i == 3) hold_busy = 1'b1;
            @(negedge clk);
        end
        wr_en = 1'b0;
        checks++; if (count !== 4'd8 || full !== 1'b1) begin errors++; $display("FAIL fill_full count %0d full %b exp 8/1", count, full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf_early got %b exp 0", overflow); end
        wr_en = 1'b1; wr_data = 8'hFF;
        @(negedge clk);
        wr_en = 1'b0;
        checks++; if (overflow !== 1'b1 || count !== 4'd8) begin errors++; $display("FAIL fill_ovf ovf %b count %0d exp 1/8", overflow, count); end
        hold_busy = 1'b0; bfm_en = 1'b1;
        wait_idle(1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fill_idle timeout"); end
        checks++; if (sent_q.size() != 9) begin errors++; $display("FAIL fill_frames got %0d exp 9", sent_q.size()); end
        for (int k = 0; k < 9; k++) begin
            got = (k < sent_q.size()) ? sent_q[k] : 8'hxx;
            checks++; if (got !== 8'(k + 1)) begin errors++; $display("FAIL fill_order[%0d] got %h exp %h", k, got, 8'(k + 1)); end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_sticky got %b exp 1", overflow); end
    endtask

    task automatic test_wrap;
        bit ok;
        int nxt = 16'h10;
        int cyc = 0;
        int maxc = 0;
        logic [7:0] got;
        sent_q.delete();
        bfm_en = 1'b1;
        while (nxt <= 8'h23 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (int'(count) > maxc) maxc = int'(count);
            if (mcount < 4 && $urandom_range(0, 2) != 0) begin
                wr_en = 1'b1; wr_data = 8'(nxt); nxt++;
            end else begin
                wr_en = 1'b0;
            end
        end
        @(negedge clk);
        wr_en = 1'b0;
        wait_idle(2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_idle timeout"); end
        checks++; if (maxc > 5) begin errors++; $display("FAIL wrap_maxcount got %0d exp <=5", maxc); end
        checks++; if (sent_q.size() != 20) begin errors++; $display("FAIL wrap_frames got %0d exp 20", sent_q.size()); end
        for (int k = 0; k < 20; k++) begin
            got = (k < sent_q.size()) ? sent_q[k] : 8'hxx;
            checks++; if (got !== 8'(16 + k)) begin errors++; $display("FAIL wrap_order[%0d] got %h exp %h", k, got, 8'(16 + k)); end
        end
        checks++; if (empty !== 1'b1 || count !== 4'd0) begin errors++; $display("FAIL wrap_empty empty %b count %0d", empty, count); end
    endtask

    task automatic test_simul;
        bit ok;
        logic [7:0] got;
        sent_q.delete();
        bfm_en = 1'b1;
        hold_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'hA1 + i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        checks++; if (count !== 4'd3 || tx_start !== 1'b0) begin errors++; $display("FAIL simul_setup count %0d start %b exp 3/0", count, tx_start); end
        hold_busy = 1'b0;
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'hA4;
        @(negedge clk);
        wr_en = 1'b0;
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL simul_count got %0d exp 3", count); end
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'hA1) begin errors++; $display("FAIL simul_pop start %b data %h exp 1/a1", tx_start, tx_data); end
        wait_idle(1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL simul_idle timeout"); end
        for (int k = 0; k < 4; k++) begin
            got = (k < sent_q.size()) ? sent_q[k] : 8'hxx;
            checks++; if (got !== 8'(8'hA1 + k)) begin errors++; $display("FAIL simul_order[%0d] got %h exp %h", k, got, 8'(8'hA1 + k)); end
        end
    endtask

    task automatic test_reset_mid;
        bit seen = 1'b0;
        sent_q.delete();
        bfm_en = 1'b0;
        hold_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'hB1 + i);
            @(negedge clk);
        end
        wr_en = 1'b0; hold_busy = 1'b0;
        for (int i = 0; i < 20 && !tx_start; i++) @(negedge clk);
        checks++; if (tx_start !== 1'b1 || count !== 4'd4) begin errors++; $display("FAIL rmid_req start %b count %0d exp 1/4", tx_start, count); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (tx_start !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL rmid_reset start %b count %0d exp 0/0", tx_start, count); end
        checks++; if (empty !== 1'b1 || overflow !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL rmid_flags empty %b ovf %b data %h", empty, overflow, tx_data); end
        rst_n = 1'b1;
        repeat (3 * GAP) begin
            @(negedge clk);
            if (tx_start) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL rmid_quiet frame requested after reset"); end
        checks++; if (sent_q.size() != 1) begin errors++; $display("FAIL rmid_frames got %0d exp 1", sent_q.size()); end
    endtask

    task automatic test_random;
        bit ok;
        bit wr;
        logic [7:0] got;
        sent_q.delete();
        exp_sent.delete();
        bfm_en = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            checks++; if (count !== 4'(mcount)) begin errors++; $display("FAIL rnd_count c%0d got %0d exp %0d", c, count, mcount); end
            checks++; if (full !== (mcount == DEPTH)) begin errors++; $display("FAIL rnd_full c%0d got %b", c, full); end
            checks++; if (empty !== (mcount == 0)) begin errors++; $display("FAIL rnd_empty c%0d got %b", c, empty); end
            checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf c%0d got %b exp %b", c, overflow, m_ovf); end
            wr = (c >= 200 && c < 260) ? 1'b1 : ($urandom_range(0, 2) == 0);
            wr_en = wr;
            wr_data = 8'($urandom);
        end
        @(negedge clk);
        wr_en = 1'b0;
        wait_idle(3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rnd_idle timeout"); end
        checks++; if (sent_q.size() != exp_sent.size()) begin errors++; $display("FAIL rnd_frames got %0d exp %0d", sent_q.size(), exp_sent.size()); end
        for (int k = 0; k < exp_sent.size(); k++) begin
            got = (k < sent_q.size()) ? sent_q[k] : 8'hxx;
            checks++; if (got !== exp_sent[k]) begin errors++; $display("FAIL rnd_order[%0d] got %h exp %h", k, got, exp_sent[k]); end
        end
    endtask

`ifdef UART_TX_QUEUE_ECHO_CR_EN
    task automatic test_echo;
        bit ok;
        logic [7:0] got;
        logic [7:0] want [3];
        want[0] = 8'h0D; want[1] = 8'h0A; want[2] = 8'h41;
        sent_q.delete();
        bfm_en = 1'b1;
        wr_en = 1'b1; wr_data = 8'h0D;
        @(negedge clk);
        wr_data = 8'h41;
        @(negedge clk);
        wr_en = 1'b0;
        wait_idle(1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL echo_idle timeout"); end
        checks++; if (sent_q.size() != 3) begin errors++; $display("FAIL echo_frames got %0d exp 3", sent_q.size()); end
        for (int k = 0; k < 3; k++) begin
            got = (k < sent_q.size()) ? sent_q[k] : 8'hxx;
            checks++; if (got !== want[k]) begin errors++; $display("FAIL echo_order[%0d] got %h exp %h", k, got, want[k]); end
        end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL echo_count got %0d exp 0", count); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_wrap();
        test_simul();
        test_reset_mid();
        test_random();
`ifdef UART_TX_QUEUE_ECHO_CR_EN
        test_echo();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
- Byte queue directly upstream of the UART transmitter.
- Accepts bytes from a producer (switch capture, command logic) through a write strobe and stores them in an internal FIFO.
- Hands bytes one at a time to the serializer using a start/busy handshake, so back-to-back writes do not get lost while a frame is on the line.
- Exposes fill status for front-panel LEDs and the display.

Parameters:
- DEPTH, 8, number of byte entries; must be a power of 2 and at least 2.
- ADDR_W, 3, log2(DEPTH).
- GAP_CLKS, 868, idle clocks inserted between frames; one bit time at 115200 baud from 100 MHz.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  synchronous active-low reset.
- wr_en  input  1  write strobe, one byte per cycle while high.
- wr_data  input  8  byte to enqueue.
- tx_busy  input  1  serializer busy; high from frame start until stop bit completes.
- tx_start  output  1  request to serializer; held until tx_busy seen high.
- tx_data  output  8  byte presented to serializer; stable while tx_start high and while tx_busy high.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set when wr_en is asserted while full.

Behaviour:
- Reset (rst_n sampled low on a clk edge) sets the following, overriding everything including a mid-frame handshake:
  - rd_ptr = wr_ptr = 0, count = 0, empty = 1, full = 0.
  - tx_start = 0, tx_data = 8'h00, overflow = 0.
  - State = IDLE, gap counter = 0.
  - A serializer already sending finishes its own frame; the queue ignores tx_busy until it is back in IDLE.
- Write path:
  - wr_en=1 and not full: wr_data is stored at wr_ptr and wr_ptr increments, wrapping mod DEPTH.
  - wr_en=1 and full: the write is dropped, overflow is set, and pointers are unchanged.
- count and flags:
  - count changes by +1 on write-only, -1 on pop-only, and 0 on simultaneous write+pop.
  - full and empty are registered and derived from the next count, so they are valid the same cycle count updates.
  - A write while full does not succeed even if a pop happens in the same cycle; full is judged on the current value.
- Pop occurs only in state LOAD:
  - tx_data <= mem[rd_ptr], rd_ptr increments and wraps, count decrements.
  - Write-to-tx_start latency from empty and IDLE is 2 clocks: write at cycle N, entry visible at N+1, LOAD at N+1, tx_start high at N+2.
- State machine:
  - IDLE: if !empty and !tx_busy, go to LOAD; else stay.
  - LOAD: pop as above, set tx_start=1, go to REQ.
  - REQ: hold tx_start=1 and tx_data. When tx_busy=1, clear tx_start and go to WAIT. No timeout.
  - WAIT: hold tx_data. When tx_busy=0, clear the gap counter and go to GAP.
  - GAP: count to GAP_CLKS-1, then go to IDLE. With GAP_CLKS=0, go straight to IDLE.
- Simultaneous events:
  - A write to an empty queue in the same cycle the machine is in IDLE is not seen until the next cycle; there is no bypass.
  - Write and pop in the same cycle both succeed when not full.
- overflow clears only on reset.
- Any state encoding outside the defined states returns to IDLE with tx_start=0.

Optional Feature:
- Macro: UART_TX_QUEUE_ECHO_CR_EN.
- Defined: when the popped byte is 8'h0D, the queue sends it and then sends 8'h0A as the next frame.
  - The 8'h0A is generated internally and does not occupy a FIFO entry.
  - It goes through LOAD/REQ/WAIT/GAP again ahead of the next queued byte.
  - count is unaffected by the injected byte.
- Not defined: bytes are sent exactly as queued; no extra state or logic is present.

Test Plan:
- Reset state: hold rst_n=0 for 3 clocks with wr_en=1 and wr_data=8'hAA -> count=0, empty=1, full=0, overflow=0, tx_start=0, tx_data=8'h00.
- Single byte: write 8'h41 with a bus-functional serializer that asserts tx_busy 1 clock after tx_start and holds it for 10 clocks:
  - tx_start rises 2 clocks after the write, with tx_data=8'h41.
  - tx_start drops the cycle after tx_busy is seen.
  - The next frame is not requested for GAP_CLKS clocks after tx_busy falls.
- Fill and overflow: with tx_busy held 1, write 9 bytes 8'h01..8'h09 on consecutive cycles:
  - The first byte is popped into REQ; the FIFO then holds 8'h02..8'h09, so full=1 and count=8.
  - A 10th write of 8'hFF -> overflow=1, count stays 8.
  - After release, frames go out as 01,02,...,09 in order and 8'hFF never appears.
- Wrap-around: stream 20 bytes 8'h10..8'h23 with a serializer model; writes pace tx so count never exceeds 5 -> all 20 transmitted in order, pointers wrap twice, empty=1 at end.
- Simultaneous write+pop: with count=3, issue a write in the LOAD cycle -> count stays 3; the written byte is transmitted after the existing three.
- Reset mid-frame: assert rst_n=0 while in REQ with 4 bytes queued -> tx_start=0 the next clock and count=0; after release with tx_busy low, no frame is requested. (With UART_TX_QUEUE_ECHO_CR_EN, an additional run: queue 8'h0D -> frames 0D then 0A.)
